vector_fetch_unit: RTL and testbench

//  Bus initiator that reads 16-bit interrupt/reset vectors from the boot ROM's top six bytes.

---
 rtl/vec_fetch_pkg.sv | 31 +++
 rtl/vector_fetch_unit.sv | 104 ++++++++++
 tb/tb_vector_fetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_fetch_pkg.sv
// rtl/vec_fetch_pkg.sv - shared types and vector offsets for the boot-ROM vector fetcher
package vec_fetch_pkg;

  typedef enum logic [1:0] {
    VEC_NMI   = 2'd0,
    VEC_RESET = 2'd1,
    VEC_IRQ   = 2'd2
  } vec_sel_t;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    IDLE  = 3'd1,
    RD_LO = 3'd2,
    RD_HI = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

  // Byte offsets of each vector's low byte above the vector table base.
  localparam logic [2:0] VEC_OFS_NMI   = 3'd0;
  localparam logic [2:0] VEC_OFS_RESET = 3'd2;
  localparam logic [2:0] VEC_OFS_IRQ   = 3'd4;

  function automatic logic [2:0] vec_ofs(input vec_sel_t sel);
    case (sel)
      VEC_NMI:   vec_ofs = VEC_OFS_NMI;
      VEC_RESET: vec_ofs = VEC_OFS_RESET;
      default:   vec_ofs = VEC_OFS_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/vector_fetch_unit.sv
// rtl/vector_fetch_unit.sv - reads little-endian 16-bit NMI/RESET/IRQ vectors from the top of boot ROM
module vector_fetch_unit
  import vec_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [1:0]            req_sel,
  output logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_cs,
  output logic                  rom_oe,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  vec_valid,
  output logic [15:0]           vec_out,
  output logic [1:0]            vec_sel,
  output logic                  busy
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("vector_fetch_unit: DATA_WIDTH must be 8");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("vector_fetch_unit: WAIT_STATES must be 0..15");
  end

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 6);

  fetch_state_t    state;
  logic [CNT_W-1:0] cnt;
  vec_sel_t        sel_q;
  vec_sel_t        vec_sel_q;
  vec_sel_t        req_eff;
  logic [7:0]      lo;

  // BRK shares the IRQ vector, so selector 3 is folded onto IRQ before latching.
  assign req_eff = (req_sel == 2'd3) ? VEC_IRQ : vec_sel_t'(req_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      cnt       <= '0;
      sel_q     <= VEC_RESET;
      lo        <= 8'h00;
      rom_addr  <= '0;
      vec_out   <= 16'h0000;
      vec_sel_q <= VEC_RESET;
    end else begin
      case (state)
        BOOT: begin
          sel_q    <= VEC_RESET;
          rom_addr <= BASE + ADDR_WIDTH'(vec_ofs(VEC_RESET));
          cnt      <= CNT_LOAD;
          state    <= RD_LO;
        end
        IDLE: begin
          if (req_valid) begin
            sel_q    <= req_eff;
            rom_addr <= BASE + ADDR_WIDTH'(vec_ofs(req_eff));
            cnt      <= CNT_LOAD;
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          if (cnt == '0) begin
            lo       <= rom_data[7:0];
            rom_addr <= rom_addr + ADDR_WIDTH'(1);
            cnt      <= CNT_LOAD;
            state    <= RD_HI;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_HI: begin
          // The high byte goes straight into the output word so DONE presents it.
          if (cnt == '0) begin
            vec_out   <= {rom_data[7:0], lo};
            vec_sel_q <= sel_q;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= BOOT;
      endcase
    end
  end

  // Bus strobes decode from state so an async reset releases the ROM without a clock.
  assign rom_cs    = (state == RD_LO) || (state == RD_HI);
  assign rom_oe    = rom_cs;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign vec_valid = (state == DONE);
  assign vec_sel   = vec_sel_q;

endmodule

// File: tb/tb_vector_fetch_unit.sv
// tb/tb_vector_fetch_unit.sv - self-checking bench for vector_fetch_unit (WAIT_STATES 0 and 3 instances)
module tb_vector_fetch_unit;

  localparam logic [13:0] BASE = 14'h3FFA;

  typedef struct {
    int         inst;
    logic [1:0] sel;
    logic [15:0] exp_vec;
    logic [1:0] exp_sel;
  } tv_t;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        req_valid [2];
  logic [1:0]  req_sel   [2];
  logic        req_ready [2];
  logic [13:0] rom_addr  [2];
  logic        rom_cs    [2];
  logic        rom_oe    [2];
  logic [7:0]  rom_data  [2];
  logic        vec_valid [2];
  logic [15:0] vec_out   [2];
  logic [1:0]  vec_sel   [2];
  logic        busy      [2];
  logic [7:0]  rom_img   [2][6];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  vector_fetch_unit #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_sel(req_sel[0]),
    .req_ready(req_ready[0]), .rom_addr(rom_addr[0]), .rom_cs(rom_cs[0]), .rom_oe(rom_oe[0]),
    .rom_data(rom_data[0]), .vec_valid(vec_valid[0]), .vec_out(vec_out[0]),
    .vec_sel(vec_sel[0]), .busy(busy[0])
  );

  vector_fetch_unit #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_sel(req_sel[1]),
    .req_ready(req_ready[1]), .rom_addr(rom_addr[1]), .rom_cs(rom_cs[1]), .rom_oe(rom_oe[1]),
    .rom_data(rom_data[1]), .vec_valid(vec_valid[1]), .vec_out(vec_out[1]),
    .vec_sel(vec_sel[1]), .busy(busy[1])
  );

  // ROM model: vector bytes from rom_img, a distinct junk pattern elsewhere or when unselected.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rom_data[i] = 8'hA5;
      if (rom_cs[i] && rom_oe[i]) begin
        if (rom_addr[i] >= BASE) rom_data[i] = rom_img[i][int'(rom_addr[i] - BASE)];
        else rom_data[i] = rom_addr[i][7:0] ^ 8'h5A;
      end
    end
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int eff_sel(input logic [1:0] s);
    return (s == 2'd3) ? 2 : int'(s);
  endfunction

  function automatic logic [15:0] model_vec(input int i, input logic [1:0] s);
    int e;
    e = eff_sel(s);
    return {rom_img[i][2*e+1], rom_img[i][2*e]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_default_image(input int i);
    rom_img[i][0] = 8'h00; rom_img[i][1] = 8'hF0;
    rom_img[i][2] = 8'h00; rom_img[i][3] = 8'hC0;
    rom_img[i][4] = 8'h00; rom_img[i][5] = 8'hF8;
  endtask

  // Called at the negedge of the first cycle after the launching edge (acceptance or BOOT exit).
  task automatic run_seq(input int i, input logic [1:0] s,
                         output logic [15:0] got_v, output logic [1:0] got_s);
    int ws, lat, e;
    logic [13:0] a;
    logic [15:0] ev;
    ws    = ws_of(i);
    lat   = 2 * (ws + 1) + 1;
    e     = eff_sel(s);
    a     = BASE + 14'(2 * e);
    ev    = model_vec(i, s);
    got_v = 16'h0;
    got_s = 2'd0;
    for (int k = 1; k <= lat; k++) begin
      if (k <= ws + 1)
        check($sformatf("bus_lo i%0d k%0d", i, k),
              32'({rom_cs[i], rom_oe[i], vec_valid[i], busy[i], rom_addr[i]}),
              32'({4'b1101, a}));
      else if (k <= 2 * ws + 2)
        check($sformatf("bus_hi i%0d k%0d", i, k),
              32'({rom_cs[i], rom_oe[i], vec_valid[i], busy[i], rom_addr[i]}),
              32'({4'b1101, a + 14'd1}));
      else begin
        check($sformatf("done_ctl i%0d", i),
              32'({rom_cs[i], rom_oe[i], vec_valid[i], busy[i], req_ready[i]}), 32'(5'b00110));
        check($sformatf("done_vec i%0d", i), 32'({vec_sel[i], vec_out[i]}), 32'({2'(e), ev}));
        got_v = vec_out[i];
        got_s = vec_sel[i];
      end
      @(negedge clk);
    end
    check($sformatf("idle_ctl i%0d", i),
          32'({rom_cs[i], rom_oe[i], vec_valid[i], busy[i], req_ready[i]}), 32'(5'b00001));
    check($sformatf("idle_hold i%0d", i), 32'({vec_sel[i], vec_out[i]}), 32'({2'(e), ev}));
  endtask

  task automatic fetch(input int i, input logic [1:0] s,
                       output logic [15:0] got_v, output logic [1:0] got_s);
    int n;
    n = 0;
    req_sel[i]   = s;
    req_valid[i] = 1'b1;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      errors++;
      $display("FAIL ready_timeout i%0d: req_ready stayed %b, required 1", i, req_ready[i]);
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    run_seq(i, s, got_v, got_s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    tv_t         tbl [8];
    logic [15:0] gv;
    logic [1:0]  gs;
    int          pk   [$];
    logic [17:0] pv   [$];
    int          acc_k;

    tbl[0] = '{0, 2'd0, 16'hF000, 2'd0};
    tbl[1] = '{0, 2'd2, 16'hF800, 2'd2};
    tbl[2] = '{0, 2'd1, 16'hC000, 2'd1};
    tbl[3] = '{0, 2'd3, 16'hF800, 2'd2};
    tbl[4] = '{1, 2'd2, 16'hF800, 2'd2};
    tbl[5] = '{1, 2'd3, 16'hF800, 2'd2};
    tbl[6] = '{1, 2'd0, 16'hF000, 2'd0};
    tbl[7] = '{1, 2'd1, 16'hC000, 2'd1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_sel[i] = 2'd0;
      set_default_image(i);
    end
    repeat (3) @(negedge clk);

    // Reset state, then the automatic RESET fetch on each instance in turn.
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ctl i%0d", i),
            32'({rom_cs[i], rom_oe[i], req_ready[i], vec_valid[i], busy[i]}), 32'(5'b00001));
      check($sformatf("rst_out i%0d", i), 32'({rom_addr[i], vec_sel[i], vec_out[i]}),
            32'({14'h0, 2'd1, 16'h0000}));
    end
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0;
      @(negedge clk);
      run_seq(i, 2'd1, gv, gs);
      check($sformatf("boot_vec i%0d", i), 32'(gv), 32'h0000C000);
    end

    for (int t = 0; t < 8; t++) begin
      fetch(tbl[t].inst, tbl[t].sel, gv, gs);
      check($sformatf("tbl%0d_vec", t), 32'(gv), 32'(tbl[t].exp_vec));
      check($sformatf("tbl%0d_sel", t), 32'(gs), 32'(tbl[t].exp_sel));
    end

    // req_valid held through a fetch while req_sel changes: one pulse per accepted request.
    acc_k = -1;
    req_sel[0]   = 2'd2;
    req_valid[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req_sel[0] = 2'd0;
      if (vec_valid[0]) begin
        pk.push_back(k);
        pv.push_back({vec_sel[0], vec_out[0]});
        check($sformatf("held_ready_in_done k%0d", k), 32'(req_ready[0]), 32'd0);
      end
      if (acc_k > 0 && k == acc_k + 1) req_valid[0] = 1'b0;
      if (req_ready[0] && k > 1 && acc_k < 0) acc_k = k;
    end
    req_valid[0] = 1'b0;
    check("held_pulse_count", 32'(pk.size()), 32'd2);
    if (pk.size() == 2) begin
      check("held_first", 32'(pv[0]), 32'({2'd2, 16'hF800}));
      check("held_second", 32'(pv[1]), 32'({2'd0, 16'hF000}));
      check("held_accept_cycle", 32'(acc_k), 32'(pk[0] + 1));
      check("held_second_cycle", 32'(pk[1]), 32'(acc_k + 2 * (ws_of(0) + 1) + 1));
    end

    // Reset during RD_HI of an NMI fetch: immediate bus release, then RESET refetch.
    req_sel[0]   = 2'd0;
    req_valid[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("midrst_rdhi", 32'({rom_cs[0], rom_addr[0]}), 32'({1'b1, 14'h3FFB}));
    #2 rst[0] = 1'b1;
    #1;
    check("midrst_async_ctl",
          32'({rom_cs[0], rom_oe[0], req_ready[0], vec_valid[0], busy[0]}), 32'(5'b00001));
    check("midrst_async_out", 32'({vec_sel[0], vec_out[0]}), 32'({2'd1, 16'h0000}));
    @(negedge clk);
    check("midrst_no_valid", 32'({vec_valid[0], vec_out[0]}), 32'h0);
    rst[0] = 1'b0;
    @(negedge clk);
    run_seq(0, 2'd1, gv, gs);
    check("midrst_boot_vec", 32'(gv), 32'h0000C000);

    // Byte order: low byte at the lower address.
    rom_img[0][2] = 8'h34;
    rom_img[0][3] = 8'h12;
    fetch(0, 2'd1, gv, gs);
    check("byte_order", 32'(gv), 32'h00001234);
    set_default_image(0);

    for (int r = 0; r < 24; r++) begin
      int ri;
      logic [1:0] rs;
      ri = int'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        for (int b = 0; b < 6; b++) rom_img[ri][b] = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      fetch(ri, rs, gv, gs);
      check($sformatf("rand%0d_vec", r), 32'(gv), 32'(model_vec(ri, rs)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
